gpr_wb_file: RTL

- Consumer end of the MEM→WB writeback interface: the general-purpose register file plus a per-register pending-write scoreboard.
- Accepts the registered writeback triple (destination address, write enable, double-width data) and a one-cycle retire strobe.
- Serves two combinational read ports to ID, with same-cycle write bypass and pending status for hazard detection.
- ID reports destination issue; WB retire clears it.

---
 rtl/gpr_wb_file_if.sv | 34 +++
 rtl/gpr_wb_file.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/gpr_wb_file_if.sv
// MEM->WB writeback bus: registered destination, write enable, 64-bit data
// and the one-cycle retire strobe. With HILO_WB_EN defined the bus also
// carries the HI/LO write enable.
interface gpr_wb_file_if #(
  parameter int AW = 5
);
  logic [AW-1:0] wb_wd_i;
  logic          wb_wreg_i;
  logic [63:0]   wb_wdata_i;
  logic          wb_commit_i;
`ifdef HILO_WB_EN
  logic          wb_whilo_i;
`endif

  modport master (
    output wb_wd_i,
    output wb_wreg_i,
    output wb_wdata_i,
`ifdef HILO_WB_EN
    output wb_whilo_i,
`endif
    output wb_commit_i
  );

  modport slave (
    input wb_wd_i,
    input wb_wreg_i,
    input wb_wdata_i,
`ifdef HILO_WB_EN
    input wb_whilo_i,
`endif
    input wb_commit_i
  );
endinterface

// File: rtl/gpr_wb_file.sv
// General-purpose register file with a per-register pending-write scoreboard.
// Two combinational read ports with same-cycle writeback bypass; ID bumps a
// register's in-flight counter on issue, WB retire drops it.
// Optional macro HILO_WB_EN adds the HI/LO pair written from the 64-bit bus.
module gpr_wb_file #(
  parameter int NREG   = 32,
  parameter int PEND_W = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  gpr_wb_file_if.slave  wb,
  input  logic          id_issue_i,
  input  logic [AW-1:0] id_issue_wd_i,
  input  logic          flush_i,
  input  logic [AW-1:0] ra_addr_i,
  input  logic [AW-1:0] rb_addr_i,
  output logic [31:0]   ra_data_o,
  output logic [31:0]   rb_data_o,
  output logic          ra_pend_o,
  output logic          rb_pend_o,
  output logic          issue_full_o,
`ifdef HILO_WB_EN
  output logic [31:0]   hi_o,
  output logic [31:0]   lo_o,
`endif
  output logic          err_o
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = {{(PEND_W-1){1'b0}}, 1'b1};

  logic [31:0]       gpr_q [NREG];
  logic [PEND_W-1:0] cnt_q [NREG];
  logic              err_q;

  logic              wr_en;
  logic              inc_en;
  logic              full;
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_vec;

  logic [AW-1:0]     rd_addr [2];
  logic [31:0]       rd_data [2];
  logic              rd_pend [2];

`ifndef HILO_WB_EN
  // Upper half of the bus only feeds HI in the HILO build.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^wb.wb_wdata_i[63:32];
`endif

  // Retire of a register-writing instruction; r0 never takes part.
  assign wr_en  = wb.wb_commit_i && wb.wb_wreg_i && (wb.wb_wd_i != '0);
  assign full   = !rst_i && (id_issue_wd_i != '0) && (cnt_q[id_issue_wd_i] == CNT_MAX);
  assign inc_en = id_issue_i && (id_issue_wd_i != '0) && !full;

  assign issue_full_o = full;
  assign err_o        = err_q;

  // Per-register issue/retire decode.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 1; i < NREG; i++) begin
      inc_vec[i] = inc_en && (id_issue_wd_i == AW'(i));
      dec_vec[i] = wr_en && (wb.wb_wd_i == AW'(i));
    end
  end

  assign rd_addr[0] = ra_addr_i;
  assign rd_addr[1] = rb_addr_i;

  // Read ports: bypass a same-cycle write, and treat a retiring write as
  // already gone when deciding whether the register is still pending.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      rd_pend[p] = 1'b0;
      if (!rst_i && rd_addr[p] != '0) begin
        if (wr_en && wb.wb_wd_i == rd_addr[p]) begin
          rd_data[p] = wb.wb_wdata_i[31:0];
          rd_pend[p] = cnt_q[rd_addr[p]] > CNT_ONE;
        end else begin
          rd_data[p] = gpr_q[rd_addr[p]];
          rd_pend[p] = cnt_q[rd_addr[p]] != '0;
        end
      end
    end
  end

  assign ra_data_o = rd_data[0];
  assign rb_data_o = rd_data[1];
  assign ra_pend_o = rd_pend[0];
  assign rb_pend_o = rd_pend[1];

  // Register array write on retire.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
    end else if (wr_en) begin
      gpr_q[wb.wb_wd_i] <= wb.wb_wdata_i[31:0];
    end
  end

  // In-flight counters: issue increments, retire decrements, flush clears.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (flush_i) begin
          cnt_q[i] <= '0;
        end else begin
          case ({inc_vec[i], dec_vec[i]})
            2'b10:   cnt_q[i] <= cnt_q[i] + CNT_ONE;
            2'b01:   if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - CNT_ONE;
            default: cnt_q[i] <= cnt_q[i];
          endcase
        end
      end
    end
  end

  // Sticky flag for a retire that had no matching issue outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (wr_en && cnt_q[wb.wb_wd_i] == '0 &&
                 !(inc_en && id_issue_wd_i == wb.wb_wd_i)) begin
      err_q <= 1'b1;
    end
  end

`ifdef HILO_WB_EN
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        hilo_wr;

  assign hilo_wr = wb.wb_commit_i && wb.wb_whilo_i;

  // HI/LO pair, written independently of the GPR path.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (hilo_wr) begin
      hi_q <= wb.wb_wdata_i[63:32];
      lo_q <= wb.wb_wdata_i[31:0];
    end
  end

  assign hi_o = rst_i ? '0 : (hilo_wr ? wb.wb_wdata_i[63:32] : hi_q);
  assign lo_o = rst_i ? '0 : (hilo_wr ? wb.wb_wdata_i[31:0]  : lo_q);
`endif

endmodule
